// File: rtl/rvfi_retire_sequencer.sv
// In-order trace table: entries are allocated at issue, completed out of order by two
// result ports, and retired from the head in allocation order.
module rvfi_retire_sequencer #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned TW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [31:0]   issue_pc,
  input  logic [31:0]   issue_insn,
  input  logic [4:0]    issue_rd,
  output logic          issue_ready,
  output logic [TW-1:0] issue_tag,
  input  logic          cmp0_valid,
  input  logic [TW-1:0] cmp0_tag,
  input  logic [31:0]   cmp0_wdata,
  input  logic          cmp1_valid,
  input  logic [TW-1:0] cmp1_tag,
  input  logic [31:0]   cmp1_wdata,
  input  logic          flush,
  output logic          ret_valid,
  input  logic          ret_ready,
  output logic [31:0]   ret_pc,
  output logic [31:0]   ret_insn,
  output logic [31:0]   ret_wdata,
  output logic [4:0]    ret_rd,
  output logic [TW:0]   count,
  output logic          err
);

  logic [TW:0]      head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic             err_q, err_d;

  logic [31:0] pc_q    [DEPTH];
  logic [31:0] insn_q  [DEPTH];
  logic [31:0] wdata_q [DEPTH];
  logic [4:0]  rd_q    [DEPTH];

  logic [TW-1:0] head_idx, tail_idx, last_idx, off0, off1;
  logic          res0, res1, dup, alloc, acc0, acc1, pop;

  assign head_idx = head_q[TW-1:0];
  assign tail_idx = tail_q[TW-1:0];
  assign last_idx = tail_idx - 1'b1;
  assign count    = tail_q - head_q;

  // A tag is resident when its distance from head is below the occupancy.
  assign off0 = cmp0_tag - head_idx;
  assign off1 = cmp1_tag - head_idx;
  assign res0 = {1'b0, off0} < count;
  assign res1 = {1'b0, off1} < count;

  // Stalled decode re-presents the youngest resident instruction; report its tag.
  assign dup         = (count != '0) && (issue_pc == pc_q[last_idx]);
  assign issue_tag   = dup ? last_idx : tail_idx;
  assign issue_ready = (count < (TW+1)'(DEPTH)) && !flush;
  assign alloc       = issue_valid && issue_ready && (issue_insn != '0) && !dup;

  assign acc0 = !flush && cmp0_valid && res0 && !done_q[cmp0_tag];
  assign acc1 = !flush && cmp1_valid && res1 && !done_q[cmp1_tag] &&
                !(cmp0_valid && (cmp0_tag == cmp1_tag));

  assign ret_valid = (count != '0) && done_q[head_idx];
  assign pop       = ret_valid && ret_ready;

  assign ret_pc    = ret_valid ? pc_q[head_idx]    : '0;
  assign ret_insn  = ret_valid ? insn_q[head_idx]  : '0;
  assign ret_wdata = ret_valid ? wdata_q[head_idx] : '0;
  assign ret_rd    = ret_valid ? rd_q[head_idx]    : '0;
  assign err       = err_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    done_d = done_q;
    err_d  = err_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      done_d = '0;
    end else begin
      if (alloc) begin
        done_d[tail_idx] = 1'b0;
        tail_d           = tail_q + 1'b1;
      end
      if (acc0) done_d[cmp0_tag] = 1'b1;
      if (acc1) done_d[cmp1_tag] = 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      if ((cmp0_valid && !acc0) || (cmp1_valid && !acc1)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // Payload needs no reset: it is only observable through done/count-qualified paths.
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_q[tail_idx]   <= issue_pc;
      insn_q[tail_idx] <= issue_insn;
      rd_q[tail_idx]   <= issue_rd;
    end
    if (acc0) wdata_q[cmp0_tag] <= cmp0_wdata;
    if (acc1) wdata_q[cmp1_tag] <= cmp1_wdata;
  end

endmodule

// File: tb/tb_rvfi_retire_sequencer.sv
// Directed bench for rvfi_retire_sequencer (DEPTH = 8) with hand-computed expectations.
module tb_rvfi_retire_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic [31:0]   issue_pc, issue_insn;
  logic [4:0]    issue_rd;
  logic          issue_ready;
  logic [TW-1:0] issue_tag;
  logic          cmp0_valid, cmp1_valid;
  logic [TW-1:0] cmp0_tag, cmp1_tag;
  logic [31:0]   cmp0_wdata, cmp1_wdata;
  logic          flush;
  logic          ret_valid, ret_ready;
  logic [31:0]   ret_pc, ret_insn, ret_wdata;
  logic [4:0]    ret_rd;
  logic [TW:0]   count;
  logic          err;

  int n_vec = 0;
  int n_err = 0;

  rvfi_retire_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_insn(issue_insn),
    .issue_rd(issue_rd), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .cmp0_valid(cmp0_valid), .cmp0_tag(cmp0_tag), .cmp0_wdata(cmp0_wdata),
    .cmp1_valid(cmp1_valid), .cmp1_tag(cmp1_tag), .cmp1_wdata(cmp1_wdata),
    .flush(flush), .ret_valid(ret_valid), .ret_ready(ret_ready),
    .ret_pc(ret_pc), .ret_insn(ret_insn), .ret_wdata(ret_wdata), .ret_rd(ret_rd),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_pc    = pc;
    issue_insn  = 32'h13;
    issue_rd    = rd;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    issue_valid = 0; issue_pc = 0; issue_insn = 0; issue_rd = 0;
    cmp0_valid = 0; cmp0_tag = 0; cmp0_wdata = 0;
    cmp1_valid = 0; cmp1_tag = 0; cmp1_wdata = 0;
    flush = 0; ret_ready = 0;
    #3;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_ret_valid", 32'(ret_valid), 32'd0);
    check_eq("rst_issue_ready", 32'(issue_ready), 32'd1);
    check_eq("rst_issue_tag", 32'(issue_tag), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Out-of-order completion, in-order retire
    for (int i = 0; i < 3; i++) begin
      issue(32'h100 + 32'(4 * i), 5'(i + 1));
      #1 check_eq("ooo_tag", 32'(issue_tag), 32'(i));
      tick();
    end
    issue_valid = 1'b0;
    check_eq("ooo_count", 32'(count), 32'd3);
    cmp0_valid = 1'b1; cmp0_tag = 3'd2; cmp0_wdata = 32'hA;
    tick();
    cmp0_tag = 3'd1; cmp0_wdata = 32'hB;
    tick();
    cmp0_tag = 3'd0; cmp0_wdata = 32'hC;
    check_eq("ooo_not_yet", 32'(ret_valid), 32'd0);
    tick();
    cmp0_valid = 1'b0;
    check_eq("ooo_ret_valid", 32'(ret_valid), 32'd1);
    check_eq("ooo_pc0", ret_pc, 32'h100);
    check_eq("ooo_wd0", ret_wdata, 32'hC);
    check_eq("ooo_rd0", 32'(ret_rd), 32'd1);
    ret_ready = 1'b1;
    tick();
    check_eq("ooo_pc1", ret_pc, 32'h104);
    check_eq("ooo_wd1", ret_wdata, 32'hB);
    tick();
    check_eq("ooo_pc2", ret_pc, 32'h108);
    check_eq("ooo_wd2", ret_wdata, 32'hA);
    tick();
    ret_ready = 1'b0;
    check_eq("ooo_empty_valid", 32'(ret_valid), 32'd0);
    check_eq("ooo_empty_count", 32'(count), 32'd0);
    check_eq("ooo_err", 32'(err), 32'd0);

    // Stalled decode re-presenting the same pc, and bubbles
    do_flush();
    issue(32'h200, 5'd3);
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("dup_tag", 32'(issue_tag), 32'd0);
      tick();
      check_eq("dup_count", 32'(count), 32'd1);
    end
    issue_pc = 32'h204; issue_insn = 32'h0;
    #1 check_eq("bubble_tag", 32'(issue_tag), 32'd1);
    tick();
    issue_valid = 1'b0;
    check_eq("bubble_count", 32'(count), 32'd1);
    do_flush();

    // Fill, overflow attempt, retire one, wrap
    for (int i = 0; i < 8; i++) begin
      issue(32'h300 + 32'(4 * i), 5'(i));
      #1 check_eq("fill_tag", 32'(issue_tag), 32'(i));
      tick();
    end
    check_eq("full_count", 32'(count), 32'd8);
    check_eq("full_ready", 32'(issue_ready), 32'd0);
    issue(32'h400, 5'd9);
    tick();
    issue_valid = 1'b0;
    check_eq("full_9th_count", 32'(count), 32'd8);
    cmp0_valid = 1'b1; cmp0_tag = 3'd0; cmp0_wdata = 32'h55;
    tick();
    cmp0_valid = 1'b0;
    check_eq("full_ret_pc", ret_pc, 32'h300);
    ret_ready = 1'b1;
    #1 check_eq("full_no_bypass", 32'(issue_ready), 32'd0);
    tick();
    ret_ready = 1'b0;
    check_eq("wrap_ready", 32'(issue_ready), 32'd1);
    check_eq("wrap_count", 32'(count), 32'd7);
    check_eq("wrap_tag", 32'(issue_tag), 32'd0);
    issue(32'h500, 5'd10);
    tick();
    issue_valid = 1'b0;
    check_eq("wrap_full", 32'(count), 32'd8);
    check_eq("wrap_head_pending", 32'(ret_valid), 32'd0);
    do_flush();

    // Dual completion: different tags both accepted; same tag keeps port 0
    for (int i = 0; i < 4; i++) begin
      issue(32'h600 + 32'(4 * i), 5'(i + 4));
      tick();
    end
    issue_valid = 1'b0;
    cmp0_valid = 1'b1; cmp0_tag = 3'd0; cmp0_wdata = 32'hA0;
    cmp1_valid = 1'b1; cmp1_tag = 3'd1; cmp1_wdata = 32'hA1;
    tick();
    check_eq("dual_diff_err", 32'(err), 32'd0);
    cmp0_tag = 3'd3; cmp0_wdata = 32'h11;
    cmp1_tag = 3'd3; cmp1_wdata = 32'h22;
    tick();
    check_eq("dual_same_err", 32'(err), 32'd1);
    cmp0_tag = 3'd2; cmp0_wdata = 32'hA2;
    cmp1_valid = 1'b0;
    tick();
    cmp0_valid = 1'b0;
    ret_ready = 1'b1;
    check_eq("dual_wd0", ret_wdata, 32'hA0);
    tick();
    check_eq("dual_wd1", ret_wdata, 32'hA1);
    tick();
    check_eq("dual_wd2", ret_wdata, 32'hA2);
    tick();
    check_eq("dual_pc3", ret_pc, 32'h60C);
    check_eq("dual_wd3", ret_wdata, 32'h11);
    tick();
    ret_ready = 1'b0;
    check_eq("dual_err_sticky", 32'(err), 32'd1);

    // Reset mid-operation, then completion to an empty tag
    issue(32'h680, 5'd1);
    tick();
    issue_valid = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    check_eq("rst2_err", 32'(err), 32'd0);
    check_eq("rst2_count", 32'(count), 32'd0);
    cmp0_valid = 1'b1; cmp0_tag = 3'd5; cmp0_wdata = 32'hDEAD;
    tick();
    cmp0_valid = 1'b0;
    check_eq("empty_cmp_err", 32'(err), 32'd1);
    check_eq("empty_cmp_count", 32'(count), 32'd0);
    check_eq("empty_cmp_valid", 32'(ret_valid), 32'd0);

    // Backpressure holds the head stable, then flush discards everything
    issue(32'h700, 5'd7);
    issue_insn = 32'h33;
    #1 check_eq("bp_tag", 32'(issue_tag), 32'd0);
    tick();
    issue_valid = 1'b0;
    cmp1_valid = 1'b1; cmp1_tag = 3'd0; cmp1_wdata = 32'h77;
    tick();
    cmp1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_pc", ret_pc, 32'h700);
      check_eq("bp_insn", ret_insn, 32'h33);
      check_eq("bp_wdata", ret_wdata, 32'h77);
      check_eq("bp_rd", 32'(ret_rd), 32'd7);
      check_eq("bp_count", 32'(count), 32'd1);
      tick();
    end
    issue(32'h704, 5'd8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    check_eq("flush_count", 32'(count), 32'd0);
    check_eq("flush_ret_valid", 32'(ret_valid), 32'd0);
    check_eq("flush_ret_pc", ret_pc, 32'h0);
    check_eq("flush_tag", 32'(issue_tag), 32'd0);
    check_eq("flush_err_kept", 32'(err), 32'd1);

    // Asynchronous reset with five entries resident
    for (int i = 0; i < 5; i++) begin
      issue(32'h800 + 32'(4 * i), 5'(i));
      tick();
    end
    issue_valid = 1'b0;
    cmp0_valid = 1'b1; cmp0_tag = 3'd0; cmp0_wdata = 32'h88;
    tick();
    cmp0_valid = 1'b0;
    check_eq("pre_arst_valid", 32'(ret_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("arst_count", 32'(count), 32'd0);
    check_eq("arst_ret_valid", 32'(ret_valid), 32'd0);
    check_eq("arst_ret_pc", ret_pc, 32'h0);
    check_eq("arst_ret_wdata", ret_wdata, 32'h0);
    check_eq("arst_ready", 32'(issue_ready), 32'd1);
    check_eq("arst_tag", 32'(issue_tag), 32'd0);
    check_eq("arst_err", 32'(err), 32'd0);
    tick();
    reset = 1'b0;
    issue(32'h900, 5'd2);
    #1 check_eq("post_arst_tag", 32'(issue_tag), 32'd0);
    tick();
    issue_valid = 1'b0;
    check_eq("post_arst_count", 32'(count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_sequencer.md
RVFI_RETIRE_SEQUENCER -- requirements
Module: rvfi_retire_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning trace table entries (power of two, 2..16); TW = log2(DEPTH).
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have issue_valid  input  1  decode stage presents an instruction for tracing.
REQ-005 SHALL have issue_pc / issue_insn  input  32 / 32  PC and encoding of the presented instruction.
REQ-006 SHALL have issue_rd  input  5  destination register address.
REQ-007 SHALL have issue_ready  output  1  table can accept an issue this cycle.
REQ-008 SHALL have issue_tag  output  TW  tag the presented instruction receives (tail index).
REQ-009 SHALL have cmp0_valid, cmp1_valid  input  1 each  result-completion strobes from the p_mux port (0) and the multi-cycle port (1).
REQ-010 SHALL have cmp0_tag, cmp1_tag  input  TW each  tag being completed.
REQ-011 SHALL have cmp0_wdata, cmp1_wdata  input  32 each  rd write data.
REQ-012 SHALL have flush  input  1  discard all in-flight entries.
REQ-013 SHALL have ret_valid  output  1  head entry is complete and presented.
REQ-014 SHALL have ret_ready  input  1  trace consumer accepts the presented entry.
REQ-015 SHALL have ret_pc, ret_insn, ret_wdata  output  32 each, and ret_rd  output  5  head entry fields.
REQ-016 SHALL have count  output  TW+1  occupied entries.
REQ-017 SHALL have err  output  1  sticky protocol-error flag.

Function
REQ-018 SHALL hold per-entry pc, insn, rd, wdata, done, plus head/tail pointers of TW+1 bits (extra wrap bit); count = tail - head.
REQ-019 SHALL drive issue_ready = (count < DEPTH) && !flush, combinationally; retire in the same cycle SHALL NOT raise issue_ready (no full bypass).
REQ-020 SHALL drive issue_tag = tail[TW-1:0] combinationally, independent of issue_valid.
REQ-021 SHALL allocate on issue_valid && issue_ready: write pc/insn/rd, clear done, increment tail, all at the same edge.
REQ-022 SHALL drop an issue whose issue_insn == 0 (bubble): no allocation, tail unchanged.
REQ-023 SHALL drop an issue whose issue_pc equals the pc of the most recently allocated entry while that entry is still resident (stalled decode re-presenting); issue_tag SHALL in that cycle report the tag of that resident entry.
REQ-024 SHALL on cmpN_valid, with the tag resident and not done, write wdata and set done at the next edge.
REQ-025 SHALL ignore a completion to a non-resident or already-done tag and set err.
REQ-026 SHALL, when both ports complete the same tag in one cycle, accept port 0 only and set err; different tags SHALL both be accepted.
REQ-027 SHALL drive ret_valid = (count != 0) && done[head], combinationally from registered state; earliest ret_valid is the cycle after the completing edge (latency 1).
REQ-028 SHALL drive ret_pc/ret_insn/ret_rd/ret_wdata from the head entry when ret_valid, else all zero.
REQ-029 SHALL pop (head+1) on ret_valid && ret_ready; ret fields SHALL remain stable while ret_valid && !ret_ready.
REQ-030 SHALL retire strictly in allocation order regardless of completion order.
REQ-031 SHALL allow issue, two completions and retire in one cycle; a completion to the tag being retired in that cycle SHALL be treated per REQ-025.
REQ-032 SHALL allow pointer wrap-around; tags are reused after DEPTH allocations.
REQ-033 SHALL on flush clear all done bits and set head = tail = 0 at the next edge; same-cycle issue, completions and retire are discarded; err is unaffected.

Reset
REQ-034 SHALL on reset assertion, asynchronously: head = tail = 0, all done = 0, err = 0, hence count = 0, ret_valid = 0, ret fields = 0, issue_ready = 1, issue_tag = 0.
REQ-035 SHALL, on reset mid-operation, discard all entries; first issue after deassertion receives tag 0.

Verification
REQ-036 Issue pc 0x100/0x104/0x108 -> tags 0,1,2; complete tag 2 then 1 then 0 (wdata 0xA,0xB,0xC) -> retire order 0x100(0xC), 0x104(0xB), 0x108(0xA), ret_valid one cycle after tag-0 completion.
REQ-037 Issue pc 0x200 three consecutive cycles with issue_valid held -> one allocation, count = 1, issue_tag = 0 each cycle; issue_insn = 0 -> no allocation.
REQ-038 Fill DEPTH=8 entries without completion -> issue_ready = 0, count = 8; 9th issue ignored; complete and retire tag 0 with ret_ready = 1 -> issue_ready = 1 next cycle, next tag = 0 (wrap).
REQ-039 cmp0 and cmp1 both tag 3 in one cycle (wdata 0x11 / 0x22) -> entry 3 wdata = 0x11, err = 1 and stays 1; completion to empty tag -> err set, no state change.
REQ-040 Head complete, ret_ready = 0 for 4 cycles -> ret fields stable, count unchanged; then flush with issue_valid = 1 -> next cycle count = 0, ret_valid = 0, issue_tag = 0.
REQ-041 Assert reset asynchronously with 5 entries resident -> outputs reach REQ-034 values before the next clk edge.
